// File: rtl/complex_matrix_load_sequencer.sv
// complex_matrix_load_sequencer
// Streams one 2x2 complex operand pair (16 words) from coefficient memory into a
// complex matrix multiplier, then waits for the multiplier's done with a timeout.
//
// Ports:
//   clk, reset (async, active-low)
//   start, abort, base_addr           - control; base_addr is latched on an accepted start
//   mem_rd_en, mem_addr, mem_rdata    - coefficient memory read port (1-cycle read latency)
//   matrix_in, imag, row, col, operand,
//   in_ready, in_finished             - multiplier load interface
//   mm_done                           - multiplier completion
//   busy, finished, timeout_err       - status
module complex_matrix_load_sequencer #(
    parameter int DATA_W  = 19,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] matrix_in,
    output logic              imag,
    output logic              row,
    output logic              col,
    output logic              operand,
    output logic              in_ready,
    output logic              in_finished,
    input  logic              mm_done,
    output logic              busy,
    output logic              finished,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WAIT_DONE} state_t;

    state_t            state, state_n;
    logic [3:0]        k, k_n;          // word index being fetched
    logic [CNT_W-1:0]  cnt, cnt_n;      // WAIT_DONE cycle counter
    logic [ADDR_W-1:0] base_q;
    logic [3:0]        fld;             // {operand,row,col,imag} of the word on matrix_in
    logic [DATA_W-1:0] hold;            // last word driven, shown while in_ready is low
    logic              vld;
    logic              accept, fin_set, to_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        cnt_n   = cnt;
        accept  = 1'b0;
        fin_set = 1'b0;
        to_set  = 1'b0;
        case (state)
            IDLE: begin
                // abort in the same cycle drops the start
                if (start && !abort) begin
                    state_n = FETCH;
                    k_n     = 4'd0;
                    accept  = 1'b1;
                end
            end
            FETCH: begin
                k_n = k + 4'd1;
                if (k == 4'hF) state_n = DRAIN;
            end
            DRAIN: begin
                state_n = WAIT_DONE;
                cnt_n   = '0;
            end
            WAIT_DONE: begin
                // done has priority over a coincident timeout
                if (mm_done) begin
                    state_n = IDLE;
                    fin_set = 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n = IDLE;
                    to_set  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_n = IDLE;
            fin_set = 1'b0;
            to_set  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k           <= '0;
            cnt         <= '0;
            base_q      <= '0;
            fld         <= '0;
            hold        <= '0;
            vld         <= 1'b0;
            in_finished <= 1'b0;
            finished    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            k   <= k_n;
            cnt <= cnt_n;
            if (accept) begin
                base_q      <= base_addr;
                timeout_err <= 1'b0;
            end else if (to_set) begin
                timeout_err <= 1'b1;
            end
            // read data lands one cycle after the strobe, so the field bits
            // follow the fetch index delayed by one cycle
            vld <= (state == FETCH) && !abort;
            if (state == FETCH && !abort) fld <= k;
            if (vld) hold <= mem_rdata;
            in_finished <= (state == DRAIN) && !abort;
            finished    <= fin_set;
        end
    end

    assign mem_rd_en = (state == FETCH);
    assign mem_addr  = (state == FETCH) ? base_q + ADDR_W'(k) : '0;
    // mem_rdata is passed straight through during a beat; the hold register
    // keeps the last value stable between runs
    assign matrix_in = vld ? mem_rdata : hold;
    assign in_ready  = vld;
    assign operand   = fld[3];
    assign row       = fld[2];
    assign col       = fld[1];
    assign imag      = fld[0];
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_complex_matrix_load_sequencer.sv
module tb_complex_matrix_load_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, abort = 1'b0, mm_done = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [18:0] mem_rdata = '0;
    logic [18:0] matrix_in;
    logic        imag, row, col, operand, in_ready, in_finished, busy, finished, timeout_err;

    int nchk = 0;
    int nfail = 0;

    complex_matrix_load_sequencer #(.DATA_W(19), .ADDR_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .base_addr(base_addr),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .matrix_in(matrix_in), .imag(imag), .row(row), .col(col), .operand(operand),
        .in_ready(in_ready), .in_finished(in_finished), .mm_done(mm_done),
        .busy(busy), .finished(finished), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    logic [18:0] mem [256];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int seqv [16] = '{52088, 79805, -24797, 58972, 118476, 8055, -114502, 49719,
                      97716, 23084, -41710, 106908, -71729, 85556, -3769, 53804};

    // per-cycle capture, index n = cycles after the start cycle S
    logic        c_ir [64], c_re [64], c_inf [64], c_bz [64], c_fn [64], c_te [64];
    logic [18:0] c_mi [64];
    logic [3:0]  c_fl [64];
    logic [7:0]  c_ra [64];

    task automatic run(input logic [7:0] base, input int done_at, input int abort_at,
                       input int start_again_at, input int ncyc);
        @(posedge clk); #1;
        base_addr = base;
        for (int n = 0; n < ncyc; n++) begin
            start   = (n == 0) || (n == start_again_at);
            mm_done = (n == done_at);
            abort   = (n == abort_at);
            if (n == 1) base_addr = 8'h00;  // base must have been latched
            c_ir[n] = in_ready;  c_re[n] = mem_rd_en; c_inf[n] = in_finished;
            c_bz[n] = busy;      c_fn[n] = finished;  c_te[n]  = timeout_err;
            c_mi[n] = matrix_in; c_ra[n] = mem_addr;
            c_fl[n] = {operand, row, col, imag};
            @(posedge clk); #1;
        end
        start = 0; mm_done = 0; abort = 0;
    endtask

    task automatic cleanup();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        nchk++;
        if ({in_ready, in_finished, busy, finished, timeout_err, mem_rd_en} !== 6'b0 ||
            matrix_in !== 19'd0 || mem_addr !== 8'd0 || {operand, row, col, imag} !== 4'd0) begin
            nfail++;
            $display("FAIL reset_outputs: ir=%b inf=%b bz=%b fn=%b te=%b re=%b mi=%0h ra=%0h fl=%b, want all 0",
                     in_ready, in_finished, busy, finished, timeout_err, mem_rd_en, matrix_in, mem_addr,
                     {operand, row, col, imag});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int ninf, nfn;
        logic [18:0] e;
        run(8'h10, 5, -1, -1, 40);  // stale done during FETCH must be ignored
        for (int k = 0; k < 16; k++) begin
            e = 19'(seqv[k]);
            nchk++;
            if (c_re[k+1] !== 1'b1 || c_ra[k+1] !== 8'h10 + 8'(k)) begin
                nfail++;
                $display("FAIL stream_rd[%0d]: re=%b addr=%0h, want 1 %0h", k, c_re[k+1], c_ra[k+1], 8'h10 + 8'(k));
            end
            nchk++;
            if (c_ir[k+2] !== 1'b1 || c_mi[k+2] !== e || c_fl[k+2] !== 4'(k)) begin
                nfail++;
                $display("FAIL stream_beat[%0d]: ir=%b mi=%0d fl=%b, want 1 %0d %b",
                         k, c_ir[k+2], $signed(c_mi[k+2]), c_fl[k+2], $signed(e), 4'(k));
            end
        end
        nchk++;
        if (c_bz[0] !== 1'b0 || c_bz[1] !== 1'b1 || c_ir[1] !== 1'b0 || c_ir[18] !== 1'b0 || c_re[17] !== 1'b0) begin
            nfail++;
            $display("FAIL stream_edges: bz0=%b bz1=%b ir1=%b ir18=%b re17=%b, want 0 1 0 0 0",
                     c_bz[0], c_bz[1], c_ir[1], c_ir[18], c_re[17]);
        end
        ninf = 0; nfn = 0;
        for (int n = 0; n < 40; n++) begin
            if (c_inf[n] === 1'b1 && n != 18) ninf++;
            if (c_fn[n] !== 1'b0) nfn++;
        end
        nchk++;
        if (c_inf[18] !== 1'b1 || ninf != 0) begin
            nfail++;
            $display("FAIL stream_in_finished: at18=%b others=%0d, want 1 0", c_inf[18], ninf);
        end
        nchk++;
        if (c_mi[20] !== 19'(53804)) begin
            nfail++;
            $display("FAIL stream_hold: mi=%0d, want 53804", $signed(c_mi[20]));
        end
        nchk++;
        if (c_te[33] !== 1'b0 || c_te[34] !== 1'b1 || c_bz[33] !== 1'b1 || c_bz[34] !== 1'b0 || nfn != 0) begin
            nfail++;
            $display("FAIL timeout: te33=%b te34=%b bz33=%b bz34=%b finished_count=%0d, want 0 1 1 0 0",
                     c_te[33], c_te[34], c_bz[33], c_bz[34], nfn);
        end
    endtask

    task automatic test_timeout_clear();
        run(8'h10, 20, -1, -1, 24);
        nchk++;
        if (c_te[0] !== 1'b1 || c_te[1] !== 1'b0 || c_te[22] !== 1'b0) begin
            nfail++;
            $display("FAIL timeout_clear: te0=%b te1=%b te22=%b, want 1 0 0", c_te[0], c_te[1], c_te[22]);
        end
        nchk++;
        if (c_fn[21] !== 1'b1 || c_bz[21] !== 1'b0 || c_fn[20] !== 1'b0) begin
            nfail++;
            $display("FAIL done_early: fn21=%b bz21=%b fn20=%b, want 1 0 0", c_fn[21], c_bz[21], c_fn[20]);
        end
    endtask

    task automatic test_done_b2b();
        run(8'h10, 25, -1, 26, 30);
        nchk++;
        if (c_fn[25] !== 1'b0 || c_fn[26] !== 1'b1 || c_fn[27] !== 1'b0 || c_bz[25] !== 1'b1 || c_bz[26] !== 1'b0) begin
            nfail++;
            $display("FAIL done: fn25=%b fn26=%b fn27=%b bz25=%b bz26=%b, want 0 1 0 1 0",
                     c_fn[25], c_fn[26], c_fn[27], c_bz[25], c_bz[26]);
        end
        nchk++;
        if (c_bz[27] !== 1'b1 || c_re[27] !== 1'b1 || c_ra[27] !== 8'h00) begin
            nfail++;
            $display("FAIL back_to_back: bz27=%b re27=%b ra27=%0h, want 1 1 0", c_bz[27], c_re[27], c_ra[27]);
        end
        cleanup();
    endtask

    task automatic test_wrap();
        logic [7:0] a;
        run(8'hF8, -1, -1, -1, 20);
        for (int k = 0; k < 16; k++) begin
            a = 8'hF8 + 8'(k);
            nchk++;
            if (c_ra[k+1] !== a || c_mi[k+2] !== mem[a] || c_fl[k+2] !== 4'(k)) begin
                nfail++;
                $display("FAIL wrap[%0d]: addr=%0h mi=%0h fl=%b, want %0h %0h %b",
                         k, c_ra[k+1], c_mi[k+2], c_fl[k+2], a, mem[a], 4'(k));
            end
        end
        cleanup();
    endtask

    task automatic test_abort();
        int bad;
        run(8'h10, -1, 9, 4, 30);
        nchk++;
        if (c_ir[9] !== 1'b1 || c_ir[10] !== 1'b0 || c_bz[10] !== 1'b0 || c_re[10] !== 1'b0 || c_mi[10] !== 19'(49719)) begin
            nfail++;
            $display("FAIL abort: ir9=%b ir10=%b bz10=%b re10=%b mi10=%0d, want 1 0 0 0 49719",
                     c_ir[9], c_ir[10], c_bz[10], c_re[10], $signed(c_mi[10]));
        end
        bad = 0;
        for (int n = 10; n < 30; n++)
            if (c_bz[n] !== 1'b0 || c_ir[n] !== 1'b0 || c_inf[n] !== 1'b0 || c_fn[n] !== 1'b0 || c_te[n] !== 1'b0) bad++;
        nchk++;
        if (bad != 0) begin
            nfail++;
            $display("FAIL abort_quiet: active_cycles=%0d, want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        base_addr = 8'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        nchk++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            nfail++;
            $display("FAIL pre_reset: ir=%b bz=%b, want 1 1", in_ready, busy);
        end
        #3 reset = 1'b0;
        #1;
        nchk++;
        if ({in_ready, in_finished, busy, finished, timeout_err, mem_rd_en} !== 6'b0 ||
            matrix_in !== 19'd0 || mem_addr !== 8'd0 || {operand, row, col, imag} !== 4'd0) begin
            nfail++;
            $display("FAIL reset_mid: ir=%b bz=%b re=%b mi=%0h ra=%0h fl=%b, want all 0",
                     in_ready, busy, mem_rd_en, matrix_in, mem_addr, {operand, row, col, imag});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        run(8'h10, -1, -1, -1, 20);
        nchk++;
        if (c_mi[2] !== 19'(52088) || c_fl[2] !== 4'd0 || c_mi[17] !== 19'(53804) || c_fl[17] !== 4'hF || c_inf[18] !== 1'b1) begin
            nfail++;
            $display("FAIL after_reset: mi2=%0d fl2=%b mi17=%0d fl17=%b inf18=%b, want 52088 0000 53804 1111 1",
                     $signed(c_mi[2]), c_fl[2], $signed(c_mi[17]), c_fl[17], c_inf[18]);
        end
        cleanup();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 19'(i * 1031 + 7);
        for (int i = 0; i < 16; i++) mem[8'h10 + i] = 19'(seqv[i]);
        for (int i = 0; i < 8; i++) begin
            mem[8'hF8 + i] = 19'(-(i * 5000 + 123));
            mem[i]         = 19'(i * 30000 + 17);
        end
        test_reset();
        test_stream();
        test_timeout_clear();
        test_done_b2b();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
